add_serial_nbit: RTL

Parametrised successor to the 1-bit combinational adder benchmark: a multi-cycle digit-serial adder/subtractor for WIDTH-bit operands, processing DIGIT bits per clock. It provides carry-out and signed-overflow flags and a start/busy/done handshake. It is a sequential benchmark for the MultiplierLUT flow: it exercises LUT + flip-flop packing, and its formal-verification testbench checks results against a golden model. With WIDTH=1, DIGIT=1, sub=0 its sum bit equals the 1-bit adder output (a XOR b).

---
 rtl/add_serial_nbit_if.sv | 25 ++
 rtl/add_serial_nbit.sv | 122 ++++++++++++
 2 files changed

// File: rtl/add_serial_nbit_if.sv
// Operand/result bundle for the digit-serial adder/subtractor.
// The master drives the request side; the slave (the adder) returns registered status and results.
interface add_serial_nbit_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, sub,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, sub,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/add_serial_nbit.sv
// Digit-serial WIDTH-bit adder/subtractor: DIGIT bits per clock, WIDTH/DIGIT compute cycles.
// Subtraction is done as A + ~B + 1, so cout reads as "no borrow".
module add_serial_nbit #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    add_serial_nbit_if.slave    bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [DIGIT-1:0] a_digit;
    logic [DIGIT-1:0] b_digit;
    logic [DIGIT:0]   digit_total;
    logic             digit_cout;
    logic             msb_cin;
    logic [WIDTH-1:0] acc_shift;
    logic             last_digit;

    assign a_digit     = a_q[DIGIT-1:0];
    assign b_digit     = b_q[DIGIT-1:0];
    assign digit_total = {1'b0, a_digit} + {1'b0, b_digit} + {{DIGIT{1'b0}}, carry_q};
    assign digit_cout  = digit_total[DIGIT];
    // Carry into the top bit of this digit, recovered from its sum bit; on the last digit this is the carry into the MSB.
    assign msb_cin     = digit_total[DIGIT-1] ^ a_digit[DIGIT-1] ^ b_digit[DIGIT-1];
    assign acc_shift   = (acc_q >> DIGIT) | (WIDTH'(digit_total[DIGIT-1:0]) << (WIDTH - DIGIT));
    assign last_digit  = (cnt_q == CW'(N - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    a_d     = bus.a;
                    b_d     = bus.b ^ {WIDTH{bus.sub}};
                    carry_d = bus.sub;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                acc_d   = acc_shift;
                carry_d = digit_cout;
                cnt_d   = cnt_q + CW'(1);
                if (last_digit) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    sum_d   = acc_shift;
                    cout_d  = digit_cout;
                    ovf_d   = msb_cin ^ digit_cout;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule
